serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands a, b, cin valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports a and b, each input, WIDTH bits, addend operands.
REQ-007 SHALL have port cin  input  1  carry-in for the addition.
REQ-008 SHALL have port out_valid  output  1  sum and carry outputs hold a completed result.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-010 SHALL have port sum  output  WIDTH  result bits.
REQ-011 SHALL have port carry  output  1  carry-out of the MSB.
REQ-012 SHALL have port ovf  output  1  signed two's-complement overflow; present only under REQ-030.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready high only in IDLE; out_valid high only in DONE.
REQ-015 SHALL accept operands on the rising edge where in_valid and in_ready are both high: capture a, b into shift registers, cin into the carry register, clear the bit counter, enter RUN.
REQ-016 In RUN, SHALL process one bit per clock, LSB first: s = a0 ^ b0 ^ c; c' = (a0 & b0) | (c & (a0 ^ b0)); realised as two cascaded half-adder stages plus OR.
REQ-017 Each RUN cycle SHALL shift s into the MSB of the sum register, shift the operand registers right by one, and increment the counter.
REQ-018 After the WIDTH-th RUN edge, SHALL enter DONE: out_valid goes high exactly WIDTH cycles after the accepting edge; sum equals (a + b + cin) mod 2^WIDTH; carry equals bit WIDTH of that sum.
REQ-019 In DONE, SHALL hold sum, carry, and ovf stable until out_ready is sampled high; on that edge SHALL return to IDLE.
REQ-020 In DONE, SHALL not accept new operands in the same cycle as out_ready; the earliest next accept is the following cycle.
REQ-021 in_valid in RUN or DONE SHALL be ignored, with no change to state or operands.
REQ-022 sum, carry, and ovf SHALL keep the last result after returning to IDLE and SHALL change only during RUN.
REQ-023 WIDTH=1 SHALL work: a single RUN cycle, then DONE.
REQ-024 Counter width SHALL be $clog2(WIDTH+1); no counter wrap-around SHALL occur within an operation.

Reset
REQ-025 Asserting rst_n low SHALL immediately force IDLE regardless of clk, including mid-RUN or in DONE; any partial result is discarded.
REQ-026 During reset: in_ready=0, out_valid=0, sum=0, carry=0, ovf=0, and operand, carry, and counter registers=0.
REQ-027 in_ready SHALL rise on the first rising clk edge after rst_n is deasserted.
REQ-028 Reset deassertion SHALL be synchronised externally; the block need not synchronise it.

Configuration
REQ-029 The macro SERIAL_ADDER_OVF_EN SHALL select overflow detection.
REQ-030 When SERIAL_ADDER_OVF_EN is defined: ovf port exists; ovf = carry-into-MSB XOR carry-out-of-MSB, registered on the final RUN edge and reset to 0.
REQ-031 When SERIAL_ADDER_OVF_EN is not defined: ovf port and its logic are absent; all other behaviour is identical.

Verification (WIDTH=8, SERIAL_ADDER_OVF_EN defined unless noted)
REQ-032 Accept a=0x00, b=0x00, cin=0 -> out_valid high 8 cycles later; sum=0x00, carry=0, ovf=0.
REQ-033 Accept a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1, ovf=0; a=0xFF, b=0x00, cin=1 -> same result.
REQ-034 Accept a=0x7F, b=0x01, cin=0 -> sum=0x80, carry=0, ovf=1; repeat without macro -> compiles, sum=0x80, carry=0.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, carry stable; in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-036 rst_n low at RUN cycle 4 of a=0xAA, b=0x55 -> outputs zero immediately; after release, accept 0x12+0x34 -> sum=0x46, carry=0.
REQ-037 Back-to-back: out_ready tied 1, in_valid tied 1 with random operands -> one result per WIDTH+2 cycles, all matching a reference model.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder, LSB first, one bit per clock with valid/ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic             rdy_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             c_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_sh;
   logic             carry_q;
   logic             h1s;
   logic             h1c;
   logic             h2c;
   logic             s;
   logic             cn;
   logic             last;
   logic             accept;

   assign h1s    = a_q[0] ^ b_q[0];
   assign h1c    = a_q[0] & b_q[0];
   assign s      = h1s ^ c_q;
   assign h2c    = h1s & c_q;
   assign cn     = h1c | h2c;
   assign last   = (cnt == LAST);
   assign accept = in_valid & rdy_q;

   always_comb begin
      sum_sh = sum_q >> 1;
      sum_sh[WIDTH-1] = s;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // in_ready is registered so it stays low throughout reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rdy_q <= 1'b0;
      end else begin
         state <= state_nx;
         rdy_q <= (state_nx == IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else if (state == IDLE) begin
         if (accept) begin
            a_q <= a;
            b_q <= b;
            c_q <= cin;
            cnt <= '0;
         end
      end else if (state == RUN) begin
         a_q   <= a_q >> 1;
         b_q   <= b_q >> 1;
         c_q   <= cn;
         cnt   <= cnt + CW'(1);
         sum_q <= sum_sh;
         if (last) carry_q <= cn;
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // on the MSB cycle c_q is the carry into the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state == RUN && last) begin
         ovf_q <= c_q ^ cn;
      end
   end

   assign ovf = ovf_q;
`endif

   assign in_ready  = rdy_q;
   assign out_valid = (state == DONE);
   assign sum       = sum_q;
   assign carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, corner sequences,
// back-to-back random traffic against an arithmetic model, plus a WIDTH=1 instance.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry;
   logic         ovf;

   logic         in_valid1;
   logic         in_ready1;
   logic [0:0]   a1;
   logic [0:0]   b1;
   logic         cin1;
   logic         out_valid1;
   logic         out_ready1;
   logic [0:0]   sum1;
   logic         carry1;
   logic         ovf1;

   int ncmp = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .cin       (cin1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .carry     (carry1)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf1)
`endif
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf  = 1'b0;
   assign ovf1 = 1'b0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       c;
      logic       v;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   // {ovf, carry, sum} from plain integer arithmetic
   function automatic logic [9:0] model(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic c);
      logic [8:0] t;
      logic       v;
      t = {1'b0, x} + {1'b0, y} + {8'd0, c};
      v = (x[7] == y[7]) && (t[7] != x[7]);
      return {v, t};
   endfunction

   task automatic wait_ready(input string nm);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({nm, " in_ready"}, in_ready, 1);
   endtask

   task automatic wait_done(input string nm, input int exp_lat);
      int k;
      k = 0;
      while (!out_valid && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({nm, " latency"}, k, exp_lat);
   endtask

   task automatic run_op(input string nm, input logic [7:0] va,
                         input logic [7:0] vb, input logic vc,
                         input logic [7:0] es, input logic ec,
                         input logic ev);
      wait_ready(nm);
      a = va;
      b = vb;
      cin = vc;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done(nm, W);
      chk({nm, " sum"}, sum, es);
      chk({nm, " carry"}, carry, ec);
`ifdef SERIAL_ADDER_OVF_EN
      chk({nm, " ovf"}, ovf, ev);
`endif
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, " idle in_ready"}, in_ready, 1);
      chk({nm, " idle out_valid"}, out_valid, 0);
   endtask

   initial begin
      logic [9:0] e;
      logic [9:0] q[$];
      int last_i;
      int nres;
      int k;
      logic [1:0] t1;

      tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[7] = '{8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1, 1'b0};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      in_valid1 = 1'b0;
      out_ready1 = 1'b0;
      a1 = '0;
      b1 = '0;
      cin1 = 1'b0;

      #12;
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst sum", sum, 0);
      chk("rst carry", carry, 0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst ovf", ovf, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel in_ready low", in_ready, 0);
      @(posedge clk);
      #1;
      chk("rel in_ready high", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                tbl[i].s, tbl[i].c, tbl[i].v);
      end

      // result must survive in IDLE
      @(posedge clk);
      #1;
      chk("idle hold sum", sum, tbl[7].s);
      chk("idle hold carry", carry, tbl[7].c);

      // DONE stall with in_valid noise
      wait_ready("hold");
      a = 8'h3C;
      b = 8'h0F;
      cin = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done("hold", W);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a = 8'($urandom);
         b = 8'($urandom);
         @(posedge clk);
         #1;
         chk("hold out_valid", out_valid, 1);
         chk("hold sum", sum, 8'h4C);
         chk("hold carry", carry, 0);
         chk("hold in_ready", in_ready, 0);
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("release in_ready", in_ready, 1);
      chk("release out_valid", out_valid, 0);
      chk("release sum", sum, 8'h4C);
      @(posedge clk);
      #1;
      chk("no accept on release", in_ready, 1);

      // asynchronous reset mid-RUN
      wait_ready("arst");
      a = 8'hAA;
      b = 8'h55;
      cin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst sum", sum, 0);
      chk("arst carry", carry, 0);
      chk("arst out_valid", out_valid, 0);
      chk("arst in_ready", in_ready, 0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("arst ovf", ovf, 0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst rel low", in_ready, 0);
      @(posedge clk);
      #1;
      chk("arst rel high", in_ready, 1);
      run_op("post arst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      // back-to-back random traffic
      out_ready = 1'b1;
      in_valid = 1'b1;
      last_i = -1;
      nres = 0;
      for (int i = 0; i < 300; i++) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("b2b unexpected result", 1, 0);
            end else begin
               e = q.pop_front();
               chk("b2b sum", sum, e[7:0]);
               chk("b2b carry", carry, e[8]);
`ifdef SERIAL_ADDER_OVF_EN
               chk("b2b ovf", ovf, e[9]);
`endif
            end
            if (last_i >= 0) chk("b2b period", i - last_i, W + 2);
            last_i = i;
            nres++;
         end
         a = 8'($urandom);
         b = 8'($urandom);
         cin = 1'($urandom);
         if (in_ready) q.push_back(model(a, b, cin));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      k = 0;
      while (q.size() != 0 && k < 20) begin
         if (out_valid) begin
            e = q.pop_front();
            chk("drain sum", sum, e[7:0]);
            chk("drain carry", carry, e[8]);
         end
         @(posedge clk);
         #1;
         k++;
      end
      out_ready = 1'b0;
      chk("b2b leftover", q.size(), 0);
      chk("b2b count ok", nres >= 25, 1);

      // WIDTH=1 instance, exhaustive
      for (int i = 0; i < 8; i++) begin
         k = 0;
         while (!in_ready1 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
         end
         a1 = i[0];
         b1 = i[1];
         cin1 = i[2];
         t1 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
         in_valid1 = 1'b1;
         @(posedge clk);
         #1;
         in_valid1 = 1'b0;
         k = 0;
         while (!out_valid1 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
         end
         chk($sformatf("w1 lat %0d", i), k, 1);
         chk($sformatf("w1 sum %0d", i), sum1, t1[0]);
         chk($sformatf("w1 carry %0d", i), carry1, t1[1]);
`ifdef SERIAL_ADDER_OVF_EN
         chk($sformatf("w1 ovf %0d", i), ovf1,
             (a1 == b1) && (t1[0] != a1[0]));
`endif
         out_ready1 = 1'b1;
         @(posedge clk);
         #1;
         out_ready1 = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
